field_load_sequencer: RTL and testbench

- Write scheduler for the bank of enable-loaded field registers in the display/clock datapath.
- Each field register loads its data when its enable is high and holds otherwise.
- Two requesters share the bank:
  - a burst source, e.g. an RTC read-out, that loads all fields in order;
  - a user-edit path that writes one field at a time.
- The block arbitrates between them, sequences the one-hot enables and the shared data bus, and reports busy/done.

---
 rtl/field_load_sequencer.sv | 115 +++++++++++
 tb/tb_field_load_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_load_sequencer.sv
// Write scheduler for a bank of enable-loaded field registers: arbitrates a full-bank burst
// source against single-field user edits and drives one-hot load enables on a shared data bus.
module field_load_sequencer #(
  parameter int unsigned NFIELDS = 6,
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               burst_start_i,
  input  logic               burst_valid_i,
  input  logic [DW-1:0]      burst_data_i,
  input  logic               burst_abort_i,
  output logic               burst_ready_o,
  input  logic               usr_req_i,
  input  logic [AW-1:0]      usr_addr_i,
  input  logic [DW-1:0]      usr_data_i,
  output logic               usr_ack_o,
  output logic               usr_err_o,
  output logic [NFIELDS-1:0] wr_en_o,
  output logic [DW-1:0]      wr_data_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {StIdle, StBurst, StUsrWr, StFin} state_e;

  localparam logic [AW:0] NFieldsC = (AW+1)'(NFIELDS);
  localparam logic [AW:0] LastIdx  = (AW+1)'(NFIELDS - 1);
  localparam logic [AW:0] CntOne   = (AW+1)'(1);

  state_e             state_q, state_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [NFIELDS-1:0] wr_en_q, wr_en_d;
  logic [DW-1:0]      wr_data_q, wr_data_d;
  logic               usr_ack_q, usr_ack_d;
  logic               usr_err_q, usr_err_d;
  logic               done_q, done_d;
  logic               addr_ok;

  assign addr_ok = ({1'b0, usr_addr_i} < NFieldsC);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    usr_ack_d = 1'b0;
    usr_err_d = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (burst_start_i) begin
          state_d = StBurst;
          cnt_d   = '0;
        end else if (usr_req_i && !usr_ack_q) begin
          // A request still high while its ack is visible is the same request, not a new one.
          usr_ack_d = 1'b1;
          if (addr_ok) begin
            wr_en_d   = NFIELDS'(1) << usr_addr_i;
            wr_data_d = usr_data_i;
            state_d   = StUsrWr;
          end else begin
            usr_err_d = 1'b1;
          end
        end
      end
      StBurst: begin
        if (burst_abort_i) begin
          state_d = StIdle;
        end else if (burst_valid_i) begin
          wr_en_d   = NFIELDS'(1) << cnt_q;
          wr_data_d = burst_data_i;
          cnt_d     = cnt_q + CntOne;
          if (cnt_q == LastIdx) begin
            done_d  = 1'b1;
            state_d = StFin;
          end
        end
      end
      StUsrWr: state_d = StIdle;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      usr_ack_q <= 1'b0;
      usr_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      usr_ack_q <= usr_ack_d;
      usr_err_q <= usr_err_d;
      done_q    <= done_d;
    end
  end

  assign burst_ready_o = (state_q == StBurst);
  assign busy_o        = (state_q != StIdle);
  assign usr_ack_o     = usr_ack_q;
  assign usr_err_o     = usr_err_q;
  assign wr_en_o       = wr_en_q;
  assign wr_data_o     = wr_data_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_field_load_sequencer.sv
// Randomized self-checking bench: a field-bank model tracks which words should land where,
// and each scenario checks per-cycle enables, acks and done pulses against the sequencing rules.
module tb_field_load_sequencer;

  localparam int NF = 6;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk, reset, burst_start, burst_valid, burst_abort, usr_req;
  logic [DW-1:0] burst_data, usr_data, wr_data;
  logic [AW-1:0] usr_addr;
  logic          burst_ready, usr_ack, usr_err, busy, done;
  logic [NF-1:0] wr_en;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [DW-1:0] bank_obs [NF];
  logic [DW-1:0] bank_exp [NF];

  field_load_sequencer #(.NFIELDS(NF), .DW(DW), .AW(AW)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .burst_start_i(burst_start),
    .burst_valid_i(burst_valid),
    .burst_data_i (burst_data),
    .burst_abort_i(burst_abort),
    .burst_ready_o(burst_ready),
    .usr_req_i    (usr_req),
    .usr_addr_i   (usr_addr),
    .usr_data_i   (usr_data),
    .usr_ack_o    (usr_ack),
    .usr_err_o    (usr_err),
    .wr_en_o      (wr_en),
    .wr_data_o    (wr_data),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // Advance one clock and sample just after the edge; mirror DUT writes into the observed bank.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NF; i++) if (wr_en[i]) bank_obs[i] = wr_data;
    if (done) done_cnt++;
  endtask

  // mode 0: continuous valid with 0x11..0x66, 1: valid low on burst cycles 2 and 4, 2: random gaps.
  task automatic run_burst(input int abort_at, input int mode);
    logic [DW-1:0] words [NF];
    logic [NF-1:0] exp_en;
    logic          v, a, exp_done;
    int acc = 0;
    int c = 0;
    int d0 = done_cnt;
    bit aborted = 0;
    for (int i = 0; i < NF; i++) words[i] = (mode == 0) ? DW'((i + 1) * 17) : DW'($urandom);
    burst_start = 1'b1;
    step();
    burst_start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || burst_ready !== 1'b1 || wr_en !== '0) begin
      n_err++;
      $display("FAIL burst_entry: got busy=%b ready=%b wr_en=%b want 1 1 0", busy, burst_ready,
               wr_en);
    end
    while (acc < NF && c < 200) begin
      c++;
      a = (abort_at >= 0 && acc == abort_at);
      if (a) v = 1'b1;
      else if (mode == 1) v = (c != 2 && c != 4);
      else if (mode == 2) v = ($urandom_range(0, 3) != 0);
      else v = 1'b1;
      burst_valid = v;
      burst_abort = a;
      burst_data  = words[acc];
      step();
      exp_en   = '0;
      exp_done = 1'b0;
      if (!a && v) begin
        exp_en       = NF'(1) << acc;
        exp_done     = (acc == NF - 1);
        bank_exp[acc] = words[acc];
      end
      n_vec++;
      if (wr_en !== exp_en) begin
        n_err++;
        $display("FAIL burst_wr_en c%0d: got %b want %b", c, wr_en, exp_en);
      end
      if (!a && v) begin
        n_vec++;
        if (wr_data !== words[acc]) begin
          n_err++;
          $display("FAIL burst_wr_data f%0d: got %h want %h", acc, wr_data, words[acc]);
        end
      end
      n_vec++;
      if (done !== exp_done || usr_ack !== 1'b0) begin
        n_err++;
        $display("FAIL burst_done_ack c%0d: got done=%b ack=%b want done=%b ack=0", c, done,
                 usr_ack, exp_done);
      end
      if (a) begin
        aborted = 1;
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL abort_idle: got busy=%b want 0", busy);
        end
        break;
      end
      if (v) acc++;
    end
    burst_valid = 1'b0;
    burst_abort = 1'b0;
    if (!aborted) begin
      n_vec++;
      if (acc != NF) begin
        n_err++;
        $display("FAIL burst_budget: got %0d words want %0d", acc, NF);
      end
      step();
      n_vec++;
      if (busy !== 1'b0 || wr_en !== '0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL burst_exit: got busy=%b wr_en=%b done=%b want 0 0 0", busy, wr_en, done);
      end
    end
    n_vec++;
    if (done_cnt - d0 != (aborted ? 0 : 1)) begin
      n_err++;
      $display("FAIL done_count: got %0d want %0d", done_cnt - d0, aborted ? 0 : 1);
    end
  endtask

  // Requester holds usr_req through the ack cycle and drops it in the following cycle.
  task automatic user_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int lat = 0;
    logic ok;
    logic [NF-1:0] exp_en;
    ok = (int'(addr) < NF);
    exp_en = ok ? (NF'(1) << addr) : '0;
    usr_req = 1'b1;
    usr_addr = addr;
    usr_data = data;
    do begin
      step();
      lat++;
    end while (usr_ack !== 1'b1 && lat < 4);
    n_vec++;
    if (lat != 1 || usr_err !== !ok || wr_en !== exp_en) begin
      n_err++;
      $display("FAIL user_ack a%0d: got lat=%0d err=%b wr_en=%b want lat=1 err=%b wr_en=%b",
               addr, lat, usr_err, wr_en, !ok, exp_en);
    end
    if (ok) begin
      bank_exp[addr] = data;
      n_vec++;
      if (wr_data !== data) begin
        n_err++;
        $display("FAIL user_data a%0d: got %h want %h", addr, wr_data, data);
      end
    end
    step();
    usr_req = 1'b0;
    n_vec++;
    if (usr_ack !== 1'b0 || wr_en !== '0) begin
      n_err++;
      $display("FAIL user_single: got ack=%b wr_en=%b want 0 0", usr_ack, wr_en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_vec++;
    if (wr_data !== '0 || usr_err !== 1'b0 || burst_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_regs: got data=%h err=%b ready=%b want 0 0 0", wr_data, usr_err,
               burst_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (wr_en !== '0 || busy !== 1'b0 || done !== 1'b0 || usr_ack !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle c%0d: got wr_en=%b busy=%b done=%b ack=%b want all 0", i, wr_en,
                 busy, done, usr_ack);
      end
    end
  endtask

  task automatic test_bank(input string tag);
    for (int i = 0; i < NF; i++) begin
      n_vec++;
      if (bank_obs[i] !== bank_exp[i]) begin
        n_err++;
        $display("FAIL bank_%s f%0d: got %h want %h", tag, i, bank_obs[i], bank_exp[i]);
      end
    end
  endtask

  task automatic test_priority();
    usr_req = 1'b1;
    usr_addr = 3'd2;
    usr_data = 8'hA5;
    run_burst(-1, 0);
    step();
    n_vec++;
    if (usr_ack !== 1'b1 || usr_err !== 1'b0 || wr_en !== 6'b000100 || wr_data !== 8'hA5) begin
      n_err++;
      $display("FAIL priority_user: got ack=%b err=%b wr_en=%b data=%h want 1 0 000100 a5",
               usr_ack, usr_err, wr_en, wr_data);
    end
    bank_exp[2] = 8'hA5;
    step();
    usr_req = 1'b0;
    test_bank("priority");
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int last = 0;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom_range(0, NF - 1));
    d = DW'($urandom);
    usr_req = 1'b1;
    usr_addr = a;
    usr_data = d;
    for (int c = 1; c <= 12 && acks < 4; c++) begin
      step();
      if (usr_ack === 1'b1) begin
        n_vec++;
        if ((acks > 0 && c - last != 2) || wr_en !== (NF'(1) << a) || wr_data !== d) begin
          n_err++;
          $display("FAIL b2b_ack%0d: got gap=%0d wr_en=%b data=%h want gap=2 wr_en=%b data=%h",
                   acks, c - last, wr_en, wr_data, NF'(1) << a, d);
        end
        bank_exp[a] = d;
        acks++;
        last = c;
        a = AW'($urandom_range(0, NF - 1));
        d = DW'($urandom);
        usr_addr = a;
        usr_data = d;
      end
    end
    usr_req = 1'b0;
    n_vec++;
    if (acks != 4) begin
      n_err++;
      $display("FAIL b2b_count: got %0d acks want 4", acks);
    end
    step();
    step();
    test_bank("b2b");
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] w;
    burst_start = 1'b1;
    step();
    burst_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = DW'($urandom);
      burst_valid = 1'b1;
      burst_data = w;
      bank_exp[i] = w;
      step();
    end
    reset = 1'b1;
    burst_data = DW'($urandom);
    step();
    reset = 1'b0;
    burst_valid = 1'b0;
    n_vec++;
    if (wr_en !== '0 || busy !== 1'b0 || done !== 1'b0 || burst_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got wr_en=%b busy=%b done=%b ready=%b want all 0", wr_en, busy,
               done, burst_ready);
    end
    test_bank("reset_mid");
    run_burst(-1, 2);
    test_bank("restart");
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        run_burst(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NF - 1)) : -1, 2);
      end else begin
        user_write(AW'($urandom_range(0, (1 << AW) - 1)), DW'($urandom));
      end
      if ($urandom_range(0, 1) == 1) step();
    end
    test_bank("random");
  endtask

  initial begin
    reset = 1'b1;
    burst_start = 1'b0;
    burst_valid = 1'b0;
    burst_abort = 1'b0;
    burst_data = '0;
    usr_req = 1'b0;
    usr_addr = '0;
    usr_data = '0;
    for (int i = 0; i < NF; i++) begin
      bank_obs[i] = '0;
      bank_exp[i] = '0;
    end
    test_reset();
    run_burst(-1, 0);
    test_bank("burst");
    run_burst(-1, 1);
    test_bank("gaps");
    test_priority();
    run_burst(3, 0);
    test_bank("abort");
    user_write(3'd7, 8'h3C);
    user_write(3'd6, 8'hC3);
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
